// File: rtl/password_key_input.sv
// Key/switch input conditioner: 2-FF synchronisers, key debounce FSM and a one-cycle load strobe.
// Optional macro LOAD_ON_RELEASE_EN moves the load strobe and digit capture to the debounced release.
module password_key_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DIGIT_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_n,
  input  logic [DIGIT_W-1:0] SW,
  output logic               load,
  output logic [DIGIT_W-1:0] digit,
  output logic               key_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic               key_meta_q, key_s_q;
  logic [DIGIT_W-1:0] sw_meta_q, sw_s_q;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_q, load_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               key_db_q, key_db_d;

  // Key synchroniser presets to "released" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= SW;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    digit_d  = digit_q;
    key_db_d = key_db_q;
    case (state_q)
      ST_IDLE: begin
        if (!key_s_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = ST_PRESSED;
          key_db_d = 1'b1;
`ifndef LOAD_ON_RELEASE_EN
          load_d   = 1'b1;
          digit_d  = sw_s_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (key_s_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // A low sample during release bounce returns to PRESSED without a new load.
        if (!key_s_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = ST_IDLE;
          key_db_d = 1'b0;
`ifdef LOAD_ON_RELEASE_EN
          load_d   = 1'b1;
          digit_d  = sw_s_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      digit_q  <= '0;
      key_db_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      digit_q  <= digit_d;
      key_db_q <= key_db_d;
    end
  end

  assign load   = load_q;
  assign digit  = digit_q;
  assign key_db = key_db_q;

endmodule

// File: tb/tb_password_key_input.sv
// Directed bench for password_key_input with DEBOUNCE_CYCLES=4; edge 0 is the first edge sampling a new key level.
module tb_password_key_input;
  localparam int D  = 4;
  localparam int DW = 4;
`ifdef LOAD_ON_RELEASE_EN
  localparam bit LOR = 1'b1;
`else
  localparam bit LOR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_n = 1'b1;
  logic [DW-1:0] sw = '0;
  logic          load;
  logic [DW-1:0] digit;
  logic          key_db;

  int n_checks = 0;
  int n_fail   = 0;
  int load_total = 0;
  int h_first_load, h_loads, h_kdb_rise, h_kdb_fall;
  bit h_kdb_all;
  int exp_digit, base, rl;
  bit a_all, b_all;

  always #5 clk = ~clk;

  password_key_input #(.DEBOUNCE_CYCLES(D), .DIGIT_W(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .key_n  (key_n),
    .SW     (sw),
    .load   (load),
    .digit  (digit),
    .key_db (key_db)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Drive key level for n edges; record load edge/count and key_db behaviour relative to edge 0.
  task automatic hold(input logic lvl, input int n);
    key_n        = lvl;
    h_first_load = -1;
    h_loads      = 0;
    h_kdb_rise   = -1;
    h_kdb_fall   = -1;
    h_kdb_all    = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (load) begin
        h_loads++;
        load_total++;
        if (h_first_load < 0) h_first_load = i;
        $display("load digit=%h at edge %0d (key_n=%0b)", digit, i, lvl);
      end
      if (key_db && h_kdb_rise < 0) h_kdb_rise = i;
      if (!key_db && h_kdb_fall < 0) h_kdb_fall = i;
      if (!key_db) h_kdb_all = 1'b0;
    end
  endtask

  initial begin
    // 1: reset held while key toggles
    rst = 1'b0; key_n = 1'b1; sw = 4'hF;
    rl = 0;
    for (int i = 0; i < 8; i++) begin
      hold((i % 2) == 1, 1);
      rl += h_loads;
    end
    check("rst_loads", 32'(rl), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_key_db", 32'(key_db), 32'd0);
    rst = 1'b1;
    hold(1'b1, 8);
    check("post_rst_loads", 32'(h_loads), 32'd0);
    check("post_rst_digit", 32'(digit), 32'd0);
    check("post_rst_kdb", 32'(h_kdb_rise), 32'(-1));

    // 2: clean press and release
    sw = 4'h3;
    hold(1'b1, 3);
    hold(1'b0, 12);
    check("t2_press_edge", 32'(h_first_load), 32'(LOR ? -1 : 6));
    check("t2_press_loads", 32'(h_loads), 32'(LOR ? 0 : 1));
    check("t2_kdb_rise", 32'(h_kdb_rise), 32'd6);
    check("t2_digit_press", 32'(digit), 32'(LOR ? 0 : 3));
    hold(1'b1, 10);
    check("t2_kdb_fall", 32'(h_kdb_fall), 32'd6);
    check("t2_rel_edge", 32'(h_first_load), 32'(LOR ? 6 : -1));
    check("t2_rel_loads", 32'(h_loads), 32'(LOR ? 1 : 0));
    check("t2_digit_rel", 32'(digit), 32'd3);

    // 3: press bounce
    sw = 4'h5;
    base = load_total;
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 1);
    check("t3_bounce_loads", 32'(load_total - base), 32'd0);
    check("t3_bounce_kdb", 32'(key_db), 32'd0);
    hold(1'b0, 8);
    check("t3_press_edge", 32'(h_first_load), 32'(LOR ? -1 : 6));
    check("t3_kdb_rise", 32'(h_kdb_rise), 32'd6);

    // 4: release bounce
    hold(1'b1, 2); a_all = h_kdb_all;
    hold(1'b0, 2); b_all = h_kdb_all;
    hold(1'b1, 8);
    check("t4_kdb_held", 32'(a_all && b_all), 32'd1);
    check("t4_kdb_fall", 32'(h_kdb_fall), 32'd6);
    check("t4_loads", 32'(load_total - base), 32'd1);
    check("t4_digit", 32'(digit), 32'd5);

    // 5: digit sequence with SW changed mid-hold
    exp_digit = 5;
    base = load_total;
    for (int d = 1; d <= 4; d++) begin
      sw = DW'(d);
      hold(1'b0, 7);
      if (!LOR) exp_digit = d;
      check("t5_press_edge", 32'(h_first_load), 32'(LOR ? -1 : 6));
      check("t5_digit_press", 32'(digit), 32'(exp_digit));
      sw = DW'(d | 8);
      hold(1'b0, 1);
      check("t5_digit_midhold", 32'(digit), 32'(exp_digit));
      hold(1'b1, 8);
      if (LOR) exp_digit = d | 8;
      check("t5_rel_edge", 32'(h_first_load), 32'(LOR ? 6 : -1));
      check("t5_digit_rel", 32'(digit), 32'(exp_digit));
    end
    check("t5_loads", 32'(load_total - base), 32'd4);

    // 6: reset mid PRESS_WAIT at edge 4
    sw = 4'h6;
    hold(1'b0, 5);
    check("t6_pre_loads", 32'(h_loads), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_async_digit", 32'(digit), 32'd0);
    check("t6_async_kdb", 32'(key_db), 32'd0);
    hold(1'b0, 1);
    check("t6_rst_loads", 32'(h_loads), 32'd0);
    rst = 1'b1;
    hold(1'b0, 10);
    check("t6_press_edge", 32'(h_first_load), 32'(LOR ? -1 : 6));
    check("t6_kdb_rise", 32'(h_kdb_rise), 32'd6);
    check("t6_digit", 32'(digit), 32'(LOR ? 0 : 6));
    hold(1'b1, 10);
    check("t6_rel_edge", 32'(h_first_load), 32'(LOR ? 6 : -1));
    check("t6_digit_rel", 32'(digit), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
